// File: rtl/hilo_pkg.sv
// hilo_pkg: shared state type and default multicycle latencies for the HI/LO unit
package hilo_pkg;
    typedef enum logic {IDLE, WAIT} hilo_state_t;
    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 8;
endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: loadable down counter that stops at zero and flags it
module hilo_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_comb zero = (cnt == '0);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO registers with fixed-latency mult/div stall, mthi/mtlo writes and mfhi/mflo reads
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    input  logic        op_muldiv,
    input  logic        op_is_div,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic        op_mfhi,
    input  logic        op_mflo,
    input  logic [31:0] wdata,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);
    hilo_state_t state;
    logic start, zero;
    always_comb begin
        start   = exe_valid & op_muldiv & ~cancel & (state == IDLE);
        // the last WAIT cycle drops busy so the stage advances on the commit edge
        busy    = resetn & ((state == IDLE) ? start : (~zero & ~cancel));
        rd_data = op_mfhi ? hi_q : op_mflo ? lo_q : '0;
    end
    hilo_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (start),
        .load_val (op_is_div ? DIV_CNT : MUL_CNT),
        .zero     (zero)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) state <= WAIT;
                else if (exe_valid & ~cancel & ~op_muldiv) begin
                    if (op_mthi) hi_q <= wdata;
                    if (op_mtlo) lo_q <= wdata;
                end
            end else if (cancel) state <= IDLE;
            else if (zero) begin
                hi_q  <= alu_hi;
                lo_q  <= alu_lo;
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end
endmodule
